// File: rtl/mem_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_pkg : op codes, FSM states and lane helpers for the MAU |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package mem_access_pkg;

    localparam int LANES  = 4;
    localparam int BYTE_W = 8;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Access size in bytes; zero marks a reserved op.
    function automatic logic [2:0] access_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: access_size = 3'd1;
            OP_LH, OP_LHU, OP_SH: access_size = 3'd2;
            OP_LW, OP_SW:         access_size = 3'd4;
            default:              access_size = 3'd0;
        endcase
    endfunction

    function automatic logic [LANES-1:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_byte_lane : per-beat lane select, store shift and load extract  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_byte_lane
    import mem_access_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        beat,
    input  logic [31:0] store_data,
    input  logic [31:0] ram_word,
    output logic [3:0]  sel,
    output logic [31:0] lane_store_data,
    output logic [31:0] load_bytes,
    output logic [3:0]  load_mask
);

    logic [3:0]  smask;
    logic [7:0]  lane_span;
    logic [31:0] store_masked;
    logic [63:0] store_span;
    logic [5:0]  byte_shift;
    logic [2:0]  rev_lanes;
    logic [5:0]  rev_shift;

    // The access is laid over an 8-lane window spanning both words;
    // beat 0 takes the low half, beat 1 the high half.
    always_comb begin
        smask        = size_mask(size);
        lane_span    = {4'b0000, smask} << offset;
        store_masked = store_data & {{BYTE_W{smask[3]}}, {BYTE_W{smask[2]}},
                                     {BYTE_W{smask[1]}}, {BYTE_W{smask[0]}}};
        byte_shift   = {1'b0, offset, 3'b000};
        rev_lanes    = 3'd4 - {1'b0, offset};
        rev_shift    = {rev_lanes, 3'b000};
        store_span   = {32'b0, store_masked} << byte_shift;
        if (beat) begin
            sel             = lane_span[7:4];
            lane_store_data = store_span[63:32];
            load_bytes      = ram_word << rev_shift;
            load_mask       = sel << rev_lanes;
        end else begin
            sel             = lane_span[3:0];
            lane_store_data = store_span[31:0];
            load_bytes      = ram_word >> byte_shift;
            load_mask       = sel >> offset;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_access_unit : MEM-stage load/store initiator with split beats  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_op,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_storeData,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_loadData,
    output logic                  o_err,
    output logic                  o_ramReadEnable,
    output logic                  o_ramWriteEnable,
    output logic [ADDR_WIDTH-1:0] o_ramAddr,
    output logic [3:0]            o_ramSel,
    output logic [DATA_WIDTH-1:0] o_ramStoreData,
    input  logic [DATA_WIDTH-1:0] i_ramLoadData
);

    state_t                state;
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           data_q;
    logic [31:0]           buf_q;
    logic                  ready_q;
    logic                  done_q;
    logic [31:0]           load_q;
    logic                  err_q;

    logic [2:0]            size_q;
    logic                  store_q;
    logic                  split;
    logic                  beat_active;
    logic                  beat_idx;
    logic [3:0]            lane_sel;
    logic [31:0]           lane_wdata;
    logic [31:0]           load_bytes;
    logic [3:0]            load_mask;
    logic [31:0]           byte_mask;
    logic [31:0]           buf_next;
    logic [31:0]           ext;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign size_q      = access_size(op_q);
    assign store_q     = op_q[3];
    assign split       = ({2'b00, addr_q[1:0]} + {1'b0, size_q}) > 4'd4;
    assign beat_active = (state == ST_BEAT0) || (state == ST_BEAT1);
    assign beat_idx    = (state == ST_BEAT1);
    assign beat_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00}
                       + {{(ADDR_WIDTH-3){1'b0}}, beat_idx, 2'b00};

    mem_byte_lane u_lane (
        .offset          (addr_q[1:0]),
        .size            (size_q),
        .beat            (beat_idx),
        .store_data      (data_q),
        .ram_word        (i_ramLoadData),
        .sel             (lane_sel),
        .lane_store_data (lane_wdata),
        .load_bytes      (load_bytes),
        .load_mask       (load_mask)
    );

    // Merge this beat's bytes so the final beat can extend in the same cycle.
    always_comb begin
        byte_mask = {{8{load_mask[3]}}, {8{load_mask[2]}},
                     {8{load_mask[1]}}, {8{load_mask[0]}}};
        buf_next  = (buf_q & ~byte_mask) | (load_bytes & byte_mask);
        case (size_q)
            3'd1:    ext = op_q[2] ? {24'b0, buf_next[7:0]}
                                   : {{24{buf_next[7]}}, buf_next[7:0]};
            3'd2:    ext = op_q[2] ? {16'b0, buf_next[15:0]}
                                   : {{16{buf_next[15]}}, buf_next[15:0]};
            default: ext = buf_next;
        endcase
        if (store_q) begin
            ext = 32'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= 4'b0;
            addr_q  <= '0;
            data_q  <= 32'b0;
            buf_q   <= 32'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            load_q  <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_valid && ready_q) begin
                        op_q   <= i_op;
                        addr_q <= i_addr;
                        data_q <= i_storeData;
                        buf_q  <= 32'b0;
                        if (access_size(i_op) == 3'd0) begin
                            state   <= ST_DONE;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            load_q  <= 32'b0;
                        end else begin
                            state   <= ST_BEAT0;
                            ready_q <= 1'b0;
                        end
                    end else begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_BEAT0: begin
                    buf_q <= buf_next;
                    if (split) begin
                        state <= ST_BEAT1;
                    end else begin
                        state   <= ST_DONE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        load_q  <= ext;
                    end
                end
                ST_BEAT1: begin
                    buf_q   <= buf_next;
                    state   <= ST_DONE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b1;
                    err_q   <= 1'b0;
                    load_q  <= ext;
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready          = ready_q;
    assign o_done           = done_q;
    assign o_loadData       = load_q;
    assign o_err            = err_q;
    assign o_ramReadEnable  = beat_active && !store_q;
    assign o_ramWriteEnable = beat_active && store_q;
    assign o_ramAddr        = beat_active ? beat_addr : '0;
    assign o_ramSel         = beat_active ? lane_sel : 4'b0;
    assign o_ramStoreData   = (beat_active && store_q) ? lane_wdata : 32'b0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_access_unit : directed vector bench with a small RAM model  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [3:0]  i_op = 4'b0;
    logic [31:0] i_addr = 32'b0;
    logic [31:0] i_storeData = 32'b0;
    logic        o_ready, o_done, o_err;
    logic [31:0] o_loadData;
    logic        ram_re, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;

    logic [31:0] mem [0:15];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_idx = 4'b0;
    logic [31:0] pre_data = 32'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_op             (i_op),
        .i_addr           (i_addr),
        .i_storeData      (i_storeData),
        .o_done           (o_done),
        .o_loadData       (o_loadData),
        .o_err            (o_err),
        .o_ramReadEnable  (ram_re),
        .o_ramWriteEnable (ram_we),
        .o_ramAddr        (ram_addr),
        .o_ramSel         (ram_sel),
        .o_ramStoreData   (ram_wdata),
        .i_ramLoadData    (ram_rdata)
    );

    assign ram_rdata = mem[ram_addr[5:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (ram_sel[k]) mem[ram_addr[5:2]][k*8 +: 8] <= ram_wdata[k*8 +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Bus sanity every cycle: no re&we together, aligned in-range address, quiet bus off-beat.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_form", {3'b0, ram_addr[31:6], ram_addr[1:0], ram_re & ram_we}, 32'b0);
            chk("idle_bus", (ram_re || ram_we) ? 32'b0
                            : (ram_addr | ram_wdata | {28'b0, ram_sel}), 32'b0);
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] exp_load,
                         input logic exp_err, input int exp_lat);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!o_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk({name, "_ready"}, {31'b0, o_ready}, 32'd1);
        i_valid = 1'b1; i_op = op; i_addr = addr; i_storeData = sd;
        @(posedge clk); #1;
        i_valid = 1'b0;
        lat = 1;
        while (!o_done && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_load"}, o_loadData, exp_load);
        chk({name, "_err"}, {31'b0, o_err}, {31'b0, exp_err});
    endtask

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] exp_load;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    localparam int NVEC  = 22;
    localparam int NPRE1 = 10;
    vec_t vecs [NVEC];

    initial begin
        vecs[0]  = '{"lw0",    OP_LW,  32'd0,  32'h0,        32'h8899AABB, 1'b0, 2};
        vecs[1]  = '{"lb1",    OP_LB,  32'd1,  32'h0,        32'hFFFFFFAA, 1'b0, 2};
        vecs[2]  = '{"lbu1",   OP_LBU, 32'd1,  32'h0,        32'h000000AA, 1'b0, 2};
        vecs[3]  = '{"lhu2",   OP_LHU, 32'd2,  32'h0,        32'h00008899, 1'b0, 2};
        vecs[4]  = '{"lh2",    OP_LH,  32'd2,  32'h0,        32'hFFFF8899, 1'b0, 2};
        vecs[5]  = '{"lh3",    OP_LH,  32'd3,  32'h0,        32'h00007788, 1'b0, 3};
        vecs[6]  = '{"lw1",    OP_LW,  32'd1,  32'h0,        32'h778899AA, 1'b0, 3};
        vecs[7]  = '{"lw3",    OP_LW,  32'd3,  32'h0,        32'h00007788, 1'b0, 3};
        vecs[8]  = '{"rsv3",   4'b0011, 32'd0, 32'h0,        32'h0,        1'b1, 1};
        vecs[9]  = '{"rsvF",   4'b1111, 32'd4, 32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{"lw4",    OP_LW,  32'd4,  32'h0,        32'h22334477, 1'b0, 2};
        vecs[11] = '{"lw8",    OP_LW,  32'd8,  32'h0,        32'hCAFEBA11, 1'b0, 2};
        vecs[12] = '{"sb14",   OP_SB,  32'd14, 32'hFFFFFF55, 32'h0,        1'b0, 2};
        vecs[13] = '{"lw12a",  OP_LW,  32'd12, 32'h0,        32'h00550000, 1'b0, 2};
        vecs[14] = '{"sh15",   OP_SH,  32'd15, 32'h1234ABCD, 32'h0,        1'b0, 3};
        vecs[15] = '{"lw12b",  OP_LW,  32'd12, 32'h0,        32'hCD550000, 1'b0, 2};
        vecs[16] = '{"lw16",   OP_LW,  32'd16, 32'h0,        32'h000000AB, 1'b0, 2};
        vecs[17] = '{"lb15",   OP_LB,  32'd15, 32'h0,        32'hFFFFFFCD, 1'b0, 2};
        vecs[18] = '{"lh7",    OP_LH,  32'd7,  32'h0,        32'h00001122, 1'b0, 3};
        vecs[19] = '{"lhu6",   OP_LHU, 32'd6,  32'h0,        32'h00002233, 1'b0, 2};
        vecs[20] = '{"sh2",    OP_SH,  32'd2,  32'h0000F00D, 32'h0,        1'b0, 2};
        vecs[21] = '{"lh2b",   OP_LH,  32'd2,  32'h0,        32'hFFFFF00D, 1'b0, 2};

        preload(4'd0, 32'h8899AABB);
        preload(4'd1, 32'h00000077);
        preload(4'd2, 32'hCAFEBA00);
        preload(4'd3, 32'h00000000);
        preload(4'd4, 32'h00000000);

        // Reset values while rst_n is still asserted.
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_done_err", {30'b0, o_done, o_err}, 32'd0);
        chk("rst_load", o_loadData, 32'd0);
        chk("rst_bus", {30'b0, ram_re, ram_we} | ram_addr | ram_wdata | {28'b0, ram_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NPRE1; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].sdata,
                  vecs[i].exp_load, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Split SW at offset 1: check each beat's strobes.
        @(negedge clk);
        i_valid = 1'b1; i_op = OP_SW; i_addr = 32'd5; i_storeData = 32'h11223344;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("sw5_b0_strobe", {30'b0, ram_re, ram_we}, 32'd1);
        chk("sw5_b0_addr", ram_addr, 32'd4);
        chk("sw5_b0_sel", {28'b0, ram_sel}, 32'hE);
        chk("sw5_b0_data", ram_wdata, 32'h22334400);
        chk("sw5_b0_ready", {31'b0, o_ready}, 32'd0);
        @(posedge clk); #1;
        chk("sw5_b1_strobe", {30'b0, ram_re, ram_we}, 32'd1);
        chk("sw5_b1_addr", ram_addr, 32'd8);
        chk("sw5_b1_sel", {28'b0, ram_sel}, 32'h1);
        chk("sw5_b1_data", {24'b0, ram_wdata[7:0]}, 32'h11);
        chk("sw5_b1_done", {31'b0, o_done}, 32'd0);
        @(posedge clk); #1;
        chk("sw5_done", {30'b0, o_done, o_err}, 32'h2);
        chk("sw5_load", o_loadData, 32'd0);
        chk("sw5_ram4", mem[1], 32'h22334477);
        chk("sw5_ram8", mem[2], 32'hCAFEBA11);

        for (int i = NPRE1; i < NVEC; i++) begin
            do_op(vecs[i].name, vecs[i].op, vecs[i].addr, vecs[i].sdata,
                  vecs[i].exp_load, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Reserved op, then a load accepted in the DONE cycle.
        @(negedge clk);
        i_valid = 1'b1; i_op = 4'b0011; i_addr = 32'd0; i_storeData = 32'h0;
        @(posedge clk); #1;
        chk("b2b_rsv_done", {29'b0, o_done, o_err, o_ready}, 32'h7);
        chk("b2b_rsv_bus", {30'b0, ram_re, ram_we}, 32'd0);
        i_op = OP_LW; i_addr = 32'd0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("b2b_beat0", {30'b0, ram_re, ram_we}, 32'h2);
        chk("b2b_sel", {28'b0, ram_sel}, 32'hF);
        chk("b2b_addr", ram_addr, 32'd0);
        chk("b2b_nodone", {31'b0, o_done}, 32'd0);
        @(posedge clk); #1;
        chk("b2b_done", {30'b0, o_done, o_err}, 32'h2);
        chk("b2b_load", o_loadData, 32'hF00DAABB);

        // Reset during BEAT0 of a split store.
        preload(4'd1, 32'h13579BDF);
        preload(4'd2, 32'h5A5A5A5A);
        @(negedge clk);
        i_valid = 1'b1; i_op = OP_SW; i_addr = 32'd5; i_storeData = 32'hA5A5A5A5;
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("rst_mid_we", {31'b0, ram_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus", {30'b0, ram_re, ram_we} | ram_addr | ram_wdata | {28'b0, ram_sel}, 32'd0);
        chk("rst_mid_ready", {31'b0, o_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ram4", mem[1], 32'h13579BDF);
        chk("rst_mid_ram8", mem[2], 32'h5A5A5A5A);
        chk("rst_mid_after", {30'b0, o_ready, o_done}, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
